// File: rtl/rs_bm_sched.sv
// Berlekamp-Massey sequencer: streams syndromes into the BM core and captures the locator.
// Optional BM-response watchdog enabled by defining RS_BM_SCHED_TIMEOUT_EN.
module rs_bm_sched #(
   parameter int MAX_LENGTH = 16,
   parameter int TIMEOUT    = 1023
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] syn_len,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] loc_deg,
   output logic       syn_rd_en,
   output logic [7:0] syn_rd_addr,
   input  logic [7:0] syn_rd_data,
   output logic       bm_reset,
   output logic       bm_enable,
   output logic [7:0] bm_syn_len,
   output logic [7:0] bm_data,
   output logic       bm_valid_in,
   input  logic [7:0] bm_poly,
   input  logic       bm_valid_out,
   output logic       loc_wr_en,
   output logic [7:0] loc_wr_addr,
   output logic [7:0] loc_wr_data
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_LAUNCH, S_FEED, S_WAIT, S_COLLECT, S_DONE
   } state_t;

   localparam logic [7:0] MAX_LEN8 = 8'(MAX_LENGTH);

   state_t     state, state_nxt;
   logic [7:0] len_q;
   logic [7:0] addr_q;
   logic [7:0] count_q;
   logic [7:0] loc_deg_q;
   logic       fwd_q;
   logic       err_q;
   logic       wr_en_q;
   logic [7:0] wr_addr_q;
   logic [7:0] wr_data_q;

   logic len_ok;
   logic accept;
   logic rd_en;
   logic capture;
   logic collect_end;
   logic timeout_hit;

   assign len_ok  = (syn_len != 8'd0) && (syn_len <= MAX_LEN8) && !syn_len[0];
   assign accept  = (state == S_IDLE) && start && len_ok;
   assign rd_en   = (state == S_FEED) && (addr_q < len_q);

   // Once the buffer is full, further coefficients are dropped and the stream is closed.
   assign capture     = bm_valid_out &&
                        ((state == S_WAIT) || ((state == S_COLLECT) && (count_q < MAX_LEN8)));
   assign collect_end = (state == S_COLLECT) && (!bm_valid_out || (count_q >= MAX_LEN8));

`ifdef RS_BM_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] tcnt_q;

   // Fires in the cycle the count reaches TIMEOUT, so the abort lands TIMEOUT cycles after feeding ends.
   assign timeout_hit = (state == S_WAIT) && !bm_valid_out && (tcnt_q == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tcnt_q <= '0;
      end else if (state == S_WAIT) begin
         tcnt_q <= tcnt_q + 1'b1;
      end else if (state == S_COLLECT) begin
         tcnt_q <= bm_valid_out ? '0 : tcnt_q + 1'b1;
      end else begin
         tcnt_q <= '0;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:    if (accept) state_nxt = S_CLEAR;
         S_CLEAR:   state_nxt = S_LAUNCH;
         S_LAUNCH:  state_nxt = S_FEED;
         S_FEED:    if (fwd_q && (addr_q == len_q)) state_nxt = S_WAIT;
         S_WAIT: begin
            if (bm_valid_out)     state_nxt = S_COLLECT;
            else if (timeout_hit) state_nxt = S_IDLE;
         end
         S_COLLECT: if (collect_end) state_nxt = S_DONE;
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         len_q     <= '0;
         addr_q    <= '0;
         count_q   <= '0;
         loc_deg_q <= '0;
         fwd_q     <= 1'b0;
         err_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state   <= state_nxt;
         err_q   <= (state == S_IDLE) && start && !len_ok;
         fwd_q   <= rd_en;
         wr_en_q <= capture;
         if (accept) begin
            len_q   <= syn_len;
            addr_q  <= '0;
            count_q <= '0;
         end
         if (rd_en) addr_q <= addr_q + 8'd1;
         if (capture) begin
            wr_addr_q <= count_q;
            wr_data_q <= bm_poly;
            count_q   <= count_q + 8'd1;
         end
         if (collect_end) loc_deg_q <= count_q - 8'd1;
      end
   end

   assign busy        = (state == S_CLEAR) || (state == S_LAUNCH) || (state == S_FEED) ||
                        (state == S_WAIT)  || (state == S_COLLECT);
   assign done        = (state == S_DONE);
   assign err         = err_q || timeout_hit;
   assign loc_deg     = loc_deg_q;
   assign syn_rd_en   = rd_en;
   assign syn_rd_addr = rd_en ? addr_q : 8'd0;
   assign bm_reset    = (state == S_CLEAR) || timeout_hit;
   assign bm_enable   = (state == S_LAUNCH);
   assign bm_syn_len  = len_q;
   assign bm_valid_in = fwd_q;
   assign bm_data     = fwd_q ? syn_rd_data : 8'd0;
   assign loc_wr_en   = wr_en_q;
   assign loc_wr_addr = wr_addr_q;
   assign loc_wr_data = wr_data_q;

endmodule

// File: tb/tb_rs_bm_sched.sv
// Self-checking bench for rs_bm_sched: event monitor plus a cycle-level expectation model.
// Define RS_BM_SCHED_TIMEOUT_EN to also exercise the watchdog (TIMEOUT=32).
module tb_rs_bm_sched;

   localparam int MAXL = 16;
   localparam int TO   = 32;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] syn_len = 8'd0;
   logic       busy, done, err;
   logic [7:0] loc_deg;
   logic       syn_rd_en;
   logic [7:0] syn_rd_addr;
   logic [7:0] syn_rd_data = 8'd0;
   logic       bm_reset, bm_enable;
   logic [7:0] bm_syn_len, bm_data;
   logic       bm_valid_in;
   logic [7:0] bm_poly = 8'd0;
   logic       bm_valid_out = 1'b0;
   logic       loc_wr_en;
   logic [7:0] loc_wr_addr, loc_wr_data;

   rs_bm_sched #(.MAX_LENGTH(MAXL), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .syn_len(syn_len),
      .busy(busy), .done(done), .err(err), .loc_deg(loc_deg),
      .syn_rd_en(syn_rd_en), .syn_rd_addr(syn_rd_addr), .syn_rd_data(syn_rd_data),
      .bm_reset(bm_reset), .bm_enable(bm_enable), .bm_syn_len(bm_syn_len),
      .bm_data(bm_data), .bm_valid_in(bm_valid_in),
      .bm_poly(bm_poly), .bm_valid_out(bm_valid_out),
      .loc_wr_en(loc_wr_en), .loc_wr_addr(loc_wr_addr), .loc_wr_data(loc_wr_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Syndrome buffer: synchronous read, data one cycle after the strobe.
   logic [7:0] mem [256];
   always @(posedge clk) if (syn_rd_en) syn_rd_data <= mem[syn_rd_addr];

   typedef struct {int c; int a; int d;} ev_t;
   ev_t rd_q[$], vin_q[$], wr_q[$], done_q[$];
   int  rst_q[$], en_q[$], err_q[$];
   int  busy_n, busy_first;
   logic [7:0] coef_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   always @(negedge clk) begin
      if (syn_rd_en)   rd_q.push_back('{cyc, int'(syn_rd_addr), 0});
      if (bm_valid_in) vin_q.push_back('{cyc, 0, int'(bm_data)});
      if (loc_wr_en)   wr_q.push_back('{cyc, int'(loc_wr_addr), int'(loc_wr_data)});
      if (done)        done_q.push_back('{cyc, int'(loc_deg), int'(bm_syn_len)});
      if (bm_reset)    rst_q.push_back(cyc);
      if (bm_enable)   en_q.push_back(cyc);
      if (err)         err_q.push_back(cyc);
      if (busy) begin
         if (busy_n == 0) busy_first = cyc;
         busy_n++;
      end
   end

   task automatic clear_mon();
      rd_q.delete(); vin_q.delete(); wr_q.delete(); done_q.delete();
      rst_q.delete(); en_q.delete(); err_q.delete();
      busy_n = 0; busy_first = -1;
   endtask

   // Runs one decode with the coefficients in coef_q, delivered gap cycles into WAIT.
   task automatic run_decode(input int len, input int gap, input bit busy_start, input string name);
      int b, t0, k, nw, c, dcyc;
      bit seen;
      k  = coef_q.size();
      nw = (k < MAXL) ? k : MAXL;
      foreach (mem[i]) mem[i] = 8'($urandom);
      clear_mon();
      @(posedge clk); #1;
      b = cyc; start = 1'b1; syn_len = 8'(len);
      t0 = b + 4 + len + gap;
      seen = 1'b0;
      for (int n = 0; n < len + gap + k + 40; n++) begin
         @(posedge clk); #1;
         c = cyc; start = 1'b0;
         if (busy_start && c == b + 5) begin
            start = 1'b1; syn_len = 8'(2 * $urandom_range(1, 8));
         end
         if (c >= t0 && c < t0 + k) begin
            bm_valid_out = 1'b1; bm_poly = coef_q[c - t0];
         end else begin
            bm_valid_out = (c == b + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            bm_poly = 8'($urandom);
         end
         @(negedge clk); #1;
         if (done_q.size() > 0) begin seen = 1'b1; break; end
      end
      bm_valid_out = 1'b0;
      dcyc = t0 + nw + 1;

      n_checks++;
      if (!seen) begin
         n_fail++; $display("FAIL %s done_timeout: got no done, want done at cycle %0d", name, dcyc);
      end
      n_checks++;
      if (done_q.size() !== 1 || done_q[0].c !== dcyc) begin
         n_fail++; $display("FAIL %s done_cycle: got %0d pulses (first %0d), want 1 at %0d",
                            name, done_q.size(), (done_q.size() > 0) ? done_q[0].c : -1, dcyc);
      end
      if (done_q.size() > 0) begin
         n_checks++;
         if (done_q[0].a !== nw - 1) begin
            n_fail++; $display("FAIL %s loc_deg: got %0d want %0d", name, done_q[0].a, nw - 1);
         end
         n_checks++;
         if (done_q[0].d !== len) begin
            n_fail++; $display("FAIL %s bm_syn_len: got %0d want %0d", name, done_q[0].d, len);
         end
      end
      n_checks++;
      if (rd_q.size() !== len) begin
         n_fail++; $display("FAIL %s rd_count: got %0d want %0d", name, rd_q.size(), len);
      end
      for (int i = 0; i < len && i < rd_q.size(); i++) begin
         n_checks++;
         if (rd_q[i].c !== b + 3 + i || rd_q[i].a !== i) begin
            n_fail++; $display("FAIL %s rd[%0d]: got cyc %0d addr %0d want cyc %0d addr %0d",
                               name, i, rd_q[i].c - b, rd_q[i].a, 3 + i, i);
         end
      end
      n_checks++;
      if (vin_q.size() !== len) begin
         n_fail++; $display("FAIL %s vin_count: got %0d want %0d", name, vin_q.size(), len);
      end
      for (int i = 0; i < len && i < vin_q.size(); i++) begin
         n_checks++;
         if (vin_q[i].c !== b + 4 + i || vin_q[i].d !== int'(mem[i])) begin
            n_fail++; $display("FAIL %s vin[%0d]: got cyc %0d data %02h want cyc %0d data %02h",
                               name, i, vin_q[i].c - b, vin_q[i].d, 4 + i, mem[i]);
         end
      end
      n_checks++;
      if (wr_q.size() !== nw) begin
         n_fail++; $display("FAIL %s wr_count: got %0d want %0d", name, wr_q.size(), nw);
      end
      for (int j = 0; j < nw && j < wr_q.size(); j++) begin
         n_checks++;
         if (wr_q[j].c !== t0 + 1 + j || wr_q[j].a !== j || wr_q[j].d !== int'(coef_q[j])) begin
            n_fail++; $display("FAIL %s wr[%0d]: got cyc %0d addr %0d data %02h want cyc %0d addr %0d data %02h",
                               name, j, wr_q[j].c, wr_q[j].a, wr_q[j].d, t0 + 1 + j, j, coef_q[j]);
         end
      end
      n_checks++;
      if (rst_q.size() !== 1 || rst_q[0] !== b + 1 || en_q.size() !== 1 || en_q[0] !== b + 2) begin
         n_fail++; $display("FAIL %s bm_ctrl: got %0d resets %0d enables, want 1 at cycle 1 and 1 at cycle 2",
                            name, rst_q.size(), en_q.size());
      end
      n_checks++;
      if (err_q.size() !== 0) begin
         n_fail++; $display("FAIL %s err: got %0d pulses want 0", name, err_q.size());
      end
      n_checks++;
      if (busy_first !== b + 1 || busy_n !== dcyc - (b + 1)) begin
         n_fail++; $display("FAIL %s busy: got first %0d count %0d want first %0d count %0d",
                            name, busy_first, busy_n, b + 1, dcyc - (b + 1));
      end
   endtask

   task automatic check_outputs_zero(input string name);
      logic [95:0] v;
      v = {busy, done, err, loc_deg, syn_rd_en, syn_rd_addr, bm_reset, bm_enable, bm_syn_len,
           bm_data, bm_valid_in, loc_wr_en, loc_wr_addr, loc_wr_data};
      n_checks++;
      if (v !== '0) begin
         n_fail++; $display("FAIL %s outputs_zero: got %h want 0", name, v);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; syn_len = 8'd8;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1; start = 1'b0;
   endtask

   task automatic test_nominal();
      coef_q = '{8'h01, 8'hA3, 8'h5C};
      run_decode(8, 0, 1'b0, "nominal");
   endtask

   task automatic test_rejects();
      int vals[5];
      int b;
      vals = '{0, 17, 7, $urandom_range(18, 255), 2 * $urandom_range(0, 7) + 1};
      foreach (vals[i]) begin
         clear_mon();
         @(posedge clk); #1;
         b = cyc; start = 1'b1; syn_len = 8'(vals[i]);
         @(posedge clk); #1;
         start = 1'b0;
         repeat (4) @(posedge clk);
         #1;
         n_checks++;
         if (err_q.size() !== 1 || err_q[0] !== b + 1) begin
            n_fail++; $display("FAIL reject_err len=%0d: got %0d pulses want 1 at cycle 1", vals[i], err_q.size());
         end
         n_checks++;
         if (busy_n !== 0 || rst_q.size() !== 0 || rd_q.size() !== 0) begin
            n_fail++; $display("FAIL reject_quiet len=%0d: got busy %0d resets %0d reads %0d want 0 0 0",
                               vals[i], busy_n, rst_q.size(), rd_q.size());
         end
      end
   endtask

   task automatic test_start_while_busy();
      coef_q = '{8'h01, 8'hA3, 8'h5C};
      run_decode(8, 0, 1'b1, "start_busy");
   endtask

   task automatic test_overflow();
      coef_q.delete();
      for (int i = 0; i < 20; i++) coef_q.push_back(8'($urandom));
      run_decode(16, 2, 1'b0, "overflow");
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (wr_q.size() !== MAXL) begin
         n_fail++; $display("FAIL overflow_late_wr: got %0d writes want %0d", wr_q.size(), MAXL);
      end
   endtask

   task automatic test_reset_mid_feed();
      int b;
      clear_mon();
      @(posedge clk); #1;
      b = cyc; start = 1'b1; syn_len = 8'd8;
      while (cyc < b + 5) begin @(posedge clk); #1; start = 1'b0; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_outputs_zero("reset_mid_feed");
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (rd_q.size() !== 3 || vin_q.size() !== 2 || busy_n !== 5) begin
         n_fail++; $display("FAIL reset_mid_feed_strobes: got rd %0d vin %0d busy %0d want 3 2 5",
                            rd_q.size(), vin_q.size(), busy_n);
      end
      coef_q = '{8'($urandom), 8'($urandom)};
      run_decode(4, 1, 1'b0, "reset_recover");
   endtask

   task automatic test_back_to_back();
      int len, k;
      for (int r = 0; r < 8; r++) begin
         len = 2 * $urandom_range(1, 8);
         k   = $urandom_range(1, 20);
         coef_q.delete();
         for (int i = 0; i < k; i++) coef_q.push_back(8'($urandom));
         run_decode(len, $urandom_range(0, 5), 1'($urandom_range(0, 1)), $sformatf("b2b%0d", r));
      end
   endtask

`ifdef RS_BM_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      int b, len, tcy;
      len = 2 * $urandom_range(1, 8);
      clear_mon();
      @(posedge clk); #1;
      b = cyc; start = 1'b1; syn_len = 8'(len);
      tcy = b + 3 + len + TO;
      @(posedge clk); #1;
      start = 1'b0;
      while (cyc < tcy + 3) begin @(posedge clk); #1; end
      n_checks++;
      if (err_q.size() !== 1 || err_q[0] !== tcy) begin
         n_fail++; $display("FAIL timeout_err: got %0d pulses (first %0d) want 1 at %0d",
                            err_q.size(), (err_q.size() > 0) ? err_q[0] : -1, tcy);
      end
      n_checks++;
      if (rst_q.size() !== 2 || rst_q[1] !== tcy) begin
         n_fail++; $display("FAIL timeout_bm_reset: got %0d pulses want 2 (second at %0d)", rst_q.size(), tcy);
      end
      n_checks++;
      if (done_q.size() !== 0 || wr_q.size() !== 0 || busy_n !== tcy - b || busy !== 1'b0) begin
         n_fail++; $display("FAIL timeout_quiet: got done %0d wr %0d busy_cycles %0d want 0 0 %0d",
                            done_q.size(), wr_q.size(), busy_n, tcy - b);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_nominal();
      test_rejects();
      test_start_while_busy();
      test_overflow();
      test_reset_mid_feed();
      test_back_to_back();
`ifdef RS_BM_SCHED_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rs_bm_sched.md
# rs_bm_sched

Sequencer for the Berlekamp-Massey key-equation stage of the RS(255,k) decoder. It sits between the syndrome buffer and the BM datapath. It reads syndromes from the buffer's synchronous read port and streams them into the BM core. It then captures the serial error-locator coefficients into the locator buffer for Chien search and reports the locator degree and completion or error status.

## Interface
- `MAX_LENGTH`, 16: maximum number of syndromes, and the size of the locator buffer.
- `TIMEOUT`, 1023: watchdog limit in cycles for the BM core response (used only with the macro).
- `clk` in 1: sole clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: single-cycle request to decode one syndrome set.
- `syn_len` in 8: number of syndromes; sampled when `start` is accepted.
- `busy` out 1: high from acceptance of `start` until return to IDLE.
- `done` out 1: one-cycle pulse when the locator has been written.
- `err` out 1: one-cycle pulse on a rejected start or a timeout.
- `loc_deg` out 8: locator degree, which is the captured coefficient count minus 1. Valid from `done` and held until the next accepted `start`.
- `syn_rd_en` out 1: syndrome buffer read strobe.
- `syn_rd_addr` out 8: syndrome read address.
- `syn_rd_data` in 8: read data, valid exactly 1 cycle after `syn_rd_en`.
- `bm_reset` out 1: one-cycle clear pulse to the BM core.
- `bm_enable` out 1: one-cycle launch pulse to the BM core.
- `bm_syn_len` out 8: latched copy of `syn_len`.
- `bm_data` out 8: syndrome byte sent to the BM core.
- `bm_valid_in` out 1: qualifies `bm_data`.
- `bm_poly` in 8: serial coefficient from the BM core, index 0 first.
- `bm_valid_out` in 1: qualifies `bm_poly`.
- `loc_wr_en` out 1: locator buffer write strobe.
- `loc_wr_addr` out 8: locator buffer write address.
- `loc_wr_data` out 8: locator buffer write data.

## Operation
- Reset (`rst_n`=0 at a clock edge):
  - The state goes to IDLE.
  - All outputs go to 0.
  - All internal counters go to 0.
  - Reset takes effect from any state, mid-sequence included. No further strobes are issued after the reset edge.
- States:
  - **IDLE**: waits for `start`.
    - A start with `syn_len`==0, or `syn_len`>`MAX_LENGTH`, or an odd `syn_len` is rejected. The block pulses `err` the next cycle and stays in IDLE with `busy`=0.
    - A valid start latches `syn_len` and goes to CLEAR.
  - **CLEAR**: assert `bm_reset` for 1 cycle, then go to LAUNCH.
  - **LAUNCH**: assert `bm_enable` for 1 cycle, then go to FEED.
  - **FEED**:
    - Issue reads at addresses 0..`syn_len`-1 on consecutive cycles.
    - Each returned byte is forwarded the cycle after its read: `bm_data`=`syn_rd_data` with `bm_valid_in`=1.
    - After the last byte has been forwarded, go to WAIT.
  - **WAIT**: wait for the first `bm_valid_out`. That cycle's coefficient is captured and the state goes to COLLECT.
  - **COLLECT**:
    - Each cycle with `bm_valid_out`=1 writes `loc_wr_data`=`bm_poly` at `loc_wr_addr`=count, then increments count.
    - The state ends on the first cycle with `bm_valid_out`=0, or when count reaches `MAX_LENGTH`. At `MAX_LENGTH` any further coefficients are dropped without a write.
    - On exit, `loc_deg` is set to count-1 and the state goes to DONE.
  - **DONE**: pulse `done`, deassert `busy`, return to IDLE.
- `start` asserted while `busy`=1 is ignored, with no `err` pulse.
- `bm_valid_out` outside WAIT and COLLECT is ignored.
- Address and count counters are 8-bit and never wrap, because they are bounded by `MAX_LENGTH`.

## Timing
- Start accepted at edge 0:
  - `busy`=1 at cycle 1.
  - `bm_reset` at cycle 1.
  - `bm_enable` at cycle 2.
  - First `syn_rd_en` at cycle 3.
  - First `bm_valid_in` at cycle 4.
  - Last `bm_valid_in` at cycle 3+`syn_len`.
- Locator writes are registered: each `loc_wr_en` follows its `bm_valid_out` by 1 cycle.
- `done` comes 1 cycle after the last write. `busy` falls in the same cycle as `done`.
- The block can accept a new `start` in the cycle after `done`.

## Configuration
- `RS_BM_SCHED_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT and restarts on each coefficient in COLLECT.
  - When it reaches `TIMEOUT` the block pulses `bm_reset` and `err` in the same cycle and returns to IDLE.
  - `done` is not asserted and `loc_deg` is not updated.
- `RS_BM_SCHED_TIMEOUT_EN` undefined: WAIT waits indefinitely; there is no counter and no timeout `err`.

## Test plan
- **Nominal decode:** `syn_len`=8, BM returns 3 coefficients {01,A3,5C} → 8 reads at addresses 0..7, 8 `bm_valid_in` at cycles 4..11, writes at addresses 0..2, `loc_deg`=2, one `done` pulse.
- **Rejected starts:** `syn_len`=0, then 17, then 7 → three `err` pulses, no `bm_reset` and no reads, `busy` stays 0.
- **Start while busy:** `start` during FEED → ignored, and the sequence completes identically to the nominal case.
- **Coefficient overflow:** BM streams 20 valid coefficients with `syn_len`=16 → exactly 16 writes at addresses 0..15, `loc_deg`=15.
- **Reset mid-FEED:** `rst_n`=0 at the 3rd read → next cycle all outputs are 0 and IDLE. A subsequent start with `syn_len`=4 decodes correctly from address 0.
- **Timeout (macro on, `TIMEOUT`=32):** BM never asserts `bm_valid_out` → `err`+`bm_reset` pulse 32 cycles after the last `bm_valid_in`, no `done`, `busy`=0.
